sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 24, SDRAM word address width; DATA_W, default 16, SDRAM data width.
REQ-002 clk_i  in  1  single system clock; all logic is synchronous to its rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 p0_rd_i / p0_wr_i  in  1 each  port 0 read/write request (host/SPI writer port).
REQ-005 p0_addr_i  in  ADDR_W, p0_data_i  in  DATA_W  port 0 address and write data.
REQ-006 p0_done_o  out  1, p0_data_o  out  DATA_W, p0_rdPending_o  out  1  port 0 completion, read data and read-in-flight flag.
REQ-007 p1_rd_i, p1_wr_i, p1_addr_i, p1_data_i, p1_done_o, p1_data_o, p1_rdPending_o  same widths as port 0; port 1 is the scanner prefetch port.
REQ-008 host_intf_rd_o / host_intf_wr_o  out  1  request to the SDRAM controller.
REQ-009 host_intf_addr_o  out  ADDR_W, host_intf_data_o  out  DATA_W  address and write data to the controller.
REQ-010 host_intf_done_i  in  1, host_intf_data_i  in  DATA_W, host_intf_rdPending_i  in  1  controller completion, read data and pending flag.

Function
REQ-011 Port protocol: requester holds rd or wr plus addr/data stable until it sees its done_o pulse; it drops the request in the cycle after done.
REQ-012 FSM states: IDLE and BUSY; a 1-bit owner register and a 1-bit priority pointer ptr.
REQ-013 In IDLE with any port requesting: grant the single requester, or ptr's port if both request; latch owner, op, addr, data; enter BUSY next cycle.
REQ-014 Latency: request seen in IDLE at cycle N -> host_intf_rd_o/wr_o asserted from cycle N+1.
REQ-015 In BUSY: drive host_intf_rd_o/wr_o/addr_o/data_o from the latched registers only; later changes on port inputs are ignored.
REQ-016 host_intf_done_i is routed combinationally to owner's done_o only; the other port's done_o stays 0.
REQ-017 host_intf_data_i is routed to both pX_data_o unconditionally; it is valid only with that port's done_o.
REQ-018 pX_rdPending_o = host_intf_rdPending_i AND (owner == X) AND BUSY.
REQ-019 On host_intf_done_i in BUSY: next state IDLE; host_intf_rd_o/wr_o are 0 next cycle; ptr is set to NOT owner. This gives at least one idle cycle between transactions.
REQ-020 A port asserting rd and wr together is granted as a write; rd is ignored.
REQ-021 host_intf_done_i arriving in IDLE is ignored: no port done_o, no state change.
REQ-022 No timeout: BUSY persists until host_intf_done_i.
REQ-023 Back-to-back: with both ports continuously requesting, grants alternate 0,1,0,1; neither port waits more than one transaction.

Reset
REQ-024 rst_i (synchronous, active-high) forces: state IDLE, ptr=0, owner=0.
REQ-025 During and after reset: host_intf_rd_o=0, host_intf_wr_o=0, host_intf_addr_o=0, host_intf_data_o=0, and all pX_done_o/pX_rdPending_o=0.
REQ-026 Reset mid-BUSY abandons the transaction without any done_o pulse; the controller shares rst_i and is reset in the same cycle.

Structure
REQ-027 ADDR_W, DATA_W and the state encoding (IDLE=0, BUSY=1) live in the shared SDRAM package, alongside the controller's constants.
REQ-028 The block is a single module with no sub-modules; the 2-way round-robin grant is inline logic.

Verification
REQ-029 Reset, then p0_wr_i=1, addr=0x000010, data=0xBEEF -> next cycle host_intf_wr_o=1, addr_o=0x000010, data_o=0xBEEF; p0_done_o pulses with host_intf_done_i; p1_done_o stays 0.
REQ-030 p0_rd_i and p1_rd_i asserted in the same cycle after reset -> port 0 granted first. After its done, one idle cycle with rd_o=0, then port 1 granted with p1_addr_i.
REQ-031 Both ports requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1.
REQ-032 Port 1 read of 0x00ABCD; model returns 0x1234 with done -> p1_data_o=0x1234 while p1_done_o=1; p1_rdPending_o follows the controller only while port 1 owns the bus.
REQ-033 rst_i asserted during BUSY (before done) -> next cycle rd_o=wr_o=0, state IDLE, no done_o pulse; a new p1 request is then granted first only if p0 is idle (ptr=0).
REQ-034 p0_addr_i changed mid-BUSY; spurious host_intf_done_i in IDLE -> host_intf_addr_o keeps the latched value; no done_o pulse for the spurious done.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM constants: data path widths, arbiter state encoding and
// the controller timing values used by the SDRAM controller.
package sdram_arbiter_pkg;

  localparam int unsigned SDRAM_ADDR_W = 24;
  localparam int unsigned SDRAM_DATA_W = 16;

  // Arbiter state encoding kept as plain constants for legacy tools.
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  // Controller timing, in clock cycles.
  localparam int unsigned SDRAM_CAS_LAT    = 2;
  localparam int unsigned SDRAM_T_RCD      = 2;
  localparam int unsigned SDRAM_T_RP       = 2;
  localparam int unsigned SDRAM_T_RFC      = 7;
  localparam int unsigned SDRAM_REFRESH_CY = 780;

  typedef logic [0:0] arb_state_t;

  // Two-way round robin: port 1 wins if it is the only requester or if
  // both request and the pointer favours it.
  function automatic logic arb_pick_p1(input logic req0, input logic req1,
                                       input logic ptr);
    return req1 & (~req0 | ptr);
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller; one
// transaction at a time, with request fields latched at grant.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = SDRAM_ADDR_W,
  parameter int unsigned DATA_W = SDRAM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_rd_i,
  input  logic              p0_wr_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_done_o,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_rdPending_o,
  input  logic              p1_rd_i,
  input  logic              p1_wr_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_done_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_rdPending_o,
  output logic              host_intf_rd_o,
  output logic              host_intf_wr_o,
  output logic [ADDR_W-1:0] host_intf_addr_o,
  output logic [DATA_W-1:0] host_intf_data_o,
  input  logic              host_intf_done_i,
  input  logic [DATA_W-1:0] host_intf_data_i,
  input  logic              host_intf_rdPending_i
);

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_ptr;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_req0;
  logic              w_req1;
  logic              w_gnt1;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic              w_busy;
  logic              w_done;

  assign w_req0   = p0_rd_i | p0_wr_i;
  assign w_req1   = p1_rd_i | p1_wr_i;
  assign w_gnt1   = arb_pick_p1(w_req0, w_req1, r_ptr);
  assign w_sel_wr = w_gnt1 ? p1_wr_i : p0_wr_i;
  assign w_sel_rd = (w_gnt1 ? p1_rd_i : p0_rd_i) & ~w_sel_wr;

  // Outputs are also masked by rst_i so they read zero in the reset cycle itself.
  assign w_busy = (r_state == ARB_BUSY) & ~rst_i;
  assign w_done = host_intf_done_i & w_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req0 | w_req1) begin
            r_state <= ARB_BUSY;
            r_owner <= w_gnt1;
            r_rd    <= w_sel_rd;
            r_wr    <= w_sel_wr;
            r_addr  <= w_gnt1 ? p1_addr_i : p0_addr_i;
            r_data  <= w_gnt1 ? p1_data_i : p0_data_i;
          end
        end
        ARB_BUSY: begin
          if (host_intf_done_i) begin
            r_state <= ARB_IDLE;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ptr   <= ~r_owner;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign host_intf_rd_o   = r_rd & ~rst_i;
  assign host_intf_wr_o   = r_wr & ~rst_i;
  assign host_intf_addr_o = rst_i ? '0 : r_addr;
  assign host_intf_data_o = rst_i ? '0 : r_data;

  assign p0_done_o      = w_done & ~r_owner;
  assign p1_done_o      = w_done &  r_owner;
  assign p0_data_o      = host_intf_data_i;
  assign p1_data_o      = host_intf_data_i;
  assign p0_rdPending_o = host_intf_rdPending_i & w_busy & ~r_owner;
  assign p1_rdPending_o = host_intf_rdPending_i & w_busy &  r_owner;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: grant table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        p0_rd_i, p0_wr_i, p1_rd_i, p1_wr_i;
  logic [23:0] p0_addr_i, p1_addr_i;
  logic [15:0] p0_data_i, p1_data_i;
  logic        p0_done_o, p1_done_o, p0_rdPending_o, p1_rdPending_o;
  logic [15:0] p0_data_o, p1_data_o;
  logic        host_intf_rd_o, host_intf_wr_o;
  logic [23:0] host_intf_addr_o;
  logic [15:0] host_intf_data_o;
  logic        host_intf_done_i;
  logic [15:0] host_intf_data_i;
  logic        host_intf_rdPending_i;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(24), .DATA_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_rd_i(p0_rd_i), .p0_wr_i(p0_wr_i), .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i),
    .p0_done_o(p0_done_o), .p0_data_o(p0_data_o), .p0_rdPending_o(p0_rdPending_o),
    .p1_rd_i(p1_rd_i), .p1_wr_i(p1_wr_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_done_o(p1_done_o), .p1_data_o(p1_data_o), .p1_rdPending_o(p1_rdPending_o),
    .host_intf_rd_o(host_intf_rd_o), .host_intf_wr_o(host_intf_wr_o),
    .host_intf_addr_o(host_intf_addr_o), .host_intf_data_o(host_intf_data_o),
    .host_intf_done_i(host_intf_done_i), .host_intf_data_i(host_intf_data_i),
    .host_intf_rdPending_i(host_intf_rdPending_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_ports();
    p0_rd_i = 0; p0_wr_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_rd_i = 0; p1_wr_i = 0; p1_addr_i = '0; p1_data_i = '0;
    host_intf_done_i = 0; host_intf_data_i = '0; host_intf_rdPending_i = 0;
  endtask

  // Reset with controller done/pending forced high to confirm they are masked.
  task automatic do_reset(input string tag);
    clr_ports();
    rst_i = 1;
    tick();
    host_intf_done_i = 1; host_intf_rdPending_i = 1;
    #1;
    chk({tag, "_rst_rd"},   host_intf_rd_o, 0);
    chk({tag, "_rst_wr"},   host_intf_wr_o, 0);
    chk({tag, "_rst_addr"}, host_intf_addr_o, 0);
    chk({tag, "_rst_data"}, host_intf_data_o, 0);
    chk({tag, "_rst_done"}, {p0_done_o, p1_done_o}, 0);
    chk({tag, "_rst_rdp"},  {p0_rdPending_o, p1_rdPending_o}, 0);
    tick();
    rst_i = 0; host_intf_done_i = 0; host_intf_rdPending_i = 0;
  endtask

  typedef struct {
    bit prime;
    bit r0, w0, r1, w1;
    bit ex_rd, ex_wr, ex_own;
  } vec_t;

  vec_t vt[10];

  // random-phase model state
  bit          act[2], mrd[2], mwr[2], lreq[2], drop_next[2], justdrop[2];
  logic [23:0] ad[2];
  logic [15:0] dt[2];
  logic [15:0] cmem[16];
  bit          cbusy, after_done, real_done, hrd, hwr;
  int          cnt, cown, pref, g, mode, n_txn;
  logic [15:0] rdata;
  logic        own;

  initial begin
    rst_i = 1;
    clr_ports();

    // grant decision table: {ptr primed to 1, requests} -> {host op, owner}
    vt[0] = '{0, 1,0,0,0, 1,0,0};
    vt[1] = '{0, 0,1,0,0, 0,1,0};
    vt[2] = '{0, 0,0,1,0, 1,0,1};
    vt[3] = '{0, 0,0,0,1, 0,1,1};
    vt[4] = '{0, 1,0,1,0, 1,0,0};
    vt[5] = '{1, 1,0,1,0, 1,0,1};
    vt[6] = '{0, 1,1,0,0, 0,1,0};
    vt[7] = '{1, 1,0,0,1, 0,1,1};
    vt[8] = '{0, 0,1,1,0, 0,1,0};
    vt[9] = '{1, 1,0,0,0, 1,0,0};

    for (int i = 0; i < 10; i++) begin
      do_reset($sformatf("vec%0d", i));
      if (vt[i].prime) begin
        p0_wr_i = 1; p0_addr_i = 24'h5;
        tick();
        host_intf_done_i = 1;
        tick();
        host_intf_done_i = 0; p0_wr_i = 0;
      end
      p0_addr_i = 24'h100; p0_data_i = 16'hA0A0;
      p1_addr_i = 24'h200; p1_data_i = 16'hB1B1;
      p0_rd_i = vt[i].r0; p0_wr_i = vt[i].w0;
      p1_rd_i = vt[i].r1; p1_wr_i = vt[i].w1;
      tick();
      chk($sformatf("vec%0d_rd", i),   host_intf_rd_o, vt[i].ex_rd);
      chk($sformatf("vec%0d_wr", i),   host_intf_wr_o, vt[i].ex_wr);
      chk($sformatf("vec%0d_addr", i), host_intf_addr_o, vt[i].ex_own ? 24'h200 : 24'h100);
      chk($sformatf("vec%0d_data", i), host_intf_data_o, vt[i].ex_own ? 16'hB1B1 : 16'hA0A0);
      host_intf_data_i = 16'h5A5A; host_intf_done_i = 1;
      #1;
      chk($sformatf("vec%0d_done0", i), p0_done_o, !vt[i].ex_own);
      chk($sformatf("vec%0d_done1", i), p1_done_o, vt[i].ex_own);
      chk($sformatf("vec%0d_rdata", i), vt[i].ex_own ? p1_data_o : p0_data_o, 16'h5A5A);
      tick();
      clr_ports();
      tick();
    end

    // single write: one-cycle latency, done routed to port 0 only
    do_reset("wr");
    p0_wr_i = 1; p0_addr_i = 24'h000010; p0_data_i = 16'hBEEF;
    #1;
    chk("wr_latency_pre", host_intf_wr_o, 0);
    tick();
    chk("wr_wr", host_intf_wr_o, 1);
    chk("wr_addr", host_intf_addr_o, 24'h000010);
    chk("wr_data", host_intf_data_o, 16'hBEEF);
    tick(); tick();
    chk("wr_hold", host_intf_wr_o, 1);
    host_intf_done_i = 1;
    #1;
    chk("wr_done0", p0_done_o, 1);
    chk("wr_done1", p1_done_o, 0);
    tick();
    host_intf_done_i = 0; p0_wr_i = 0;
    chk("wr_after_done", host_intf_wr_o, 0);

    // simultaneous reads: port 0 first, one idle cycle, then port 1
    do_reset("both");
    p0_rd_i = 1; p0_addr_i = 24'h111; p1_rd_i = 1; p1_addr_i = 24'h222;
    tick();
    chk("both_first_addr", host_intf_addr_o, 24'h111);
    host_intf_done_i = 1;
    tick();
    host_intf_done_i = 0; p0_rd_i = 0;
    chk("both_idle_gap", host_intf_rd_o, 0);
    tick();
    chk("both_second_rd", host_intf_rd_o, 1);
    chk("both_second_addr", host_intf_addr_o, 24'h222);
    host_intf_done_i = 1;
    #1;
    chk("both_second_done1", p1_done_o, 1);
    tick();
    clr_ports();

    // continuous contention: grants alternate 0,1,0,1,0,1
    do_reset("rr");
    p0_rd_i = 1; p0_addr_i = 24'h100; p1_rd_i = 1; p1_addr_i = 24'h200;
    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 6 && !host_intf_rd_o; w++) tick();
      chk($sformatf("rr_seen%0d", t), host_intf_rd_o, 1);
      own = (host_intf_addr_o == 24'h200);
      chk($sformatf("rr_order%0d", t), own, t % 2);
      host_intf_done_i = 1;
      tick();
      host_intf_done_i = 0;
      if (own) p1_rd_i = 0; else p0_rd_i = 0;
      tick();
      p0_rd_i = 1; p1_rd_i = 1;
    end
    clr_ports();

    // port 1 read with pending flag and returned data
    do_reset("p1rd");
    p1_rd_i = 1; p1_addr_i = 24'h00ABCD;
    host_intf_rdPending_i = 1;
    #1;
    chk("p1rd_rdp_idle", p1_rdPending_o, 0);
    tick();
    chk("p1rd_addr", host_intf_addr_o, 24'h00ABCD);
    chk("p1rd_rdp1", p1_rdPending_o, 1);
    chk("p1rd_rdp0", p0_rdPending_o, 0);
    host_intf_data_i = 16'h1234; host_intf_done_i = 1;
    #1;
    chk("p1rd_done1", p1_done_o, 1);
    chk("p1rd_done0", p0_done_o, 0);
    chk("p1rd_data", p1_data_o, 16'h1234);
    tick();
    host_intf_done_i = 0; p1_rd_i = 0;
    #1;
    chk("p1rd_rdp_after", p1_rdPending_o, 0);
    clr_ports();

    // reset mid-transaction abandons it silently
    do_reset("midrst");
    p0_rd_i = 1; p0_addr_i = 24'h333;
    tick();
    chk("midrst_busy", host_intf_rd_o, 1);
    rst_i = 1; host_intf_done_i = 1;
    #1;
    chk("midrst_nodone", {p0_done_o, p1_done_o}, 0);
    chk("midrst_rd_during", host_intf_rd_o, 0);
    tick();
    rst_i = 0; host_intf_done_i = 0; p0_rd_i = 0;
    p1_rd_i = 1; p1_addr_i = 24'h444;
    #1;
    chk("midrst_rd_after", host_intf_rd_o, 0);
    tick();
    chk("midrst_p1_grant", host_intf_addr_o, 24'h444);
    host_intf_done_i = 1;
    tick();
    clr_ports();

    // latched address and spurious done in idle
    do_reset("latch");
    p0_rd_i = 1; p0_addr_i = 24'h000010;
    tick();
    p0_addr_i = 24'h000077;
    tick();
    chk("latch_addr", host_intf_addr_o, 24'h000010);
    host_intf_done_i = 1;
    tick();
    host_intf_done_i = 0; p0_rd_i = 0;
    tick();
    host_intf_done_i = 1;
    #1;
    chk("spur_done", {p0_done_o, p1_done_o}, 0);
    tick();
    host_intf_done_i = 0;
    chk("spur_state", {host_intf_rd_o, host_intf_wr_o}, 0);

    // randomized run against the transaction-level model
    do_reset("rand");
    for (int i = 0; i < 16; i++) cmem[i] = 16'(i * 16'h1111 + 16'h0F0F);
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; mrd[p] = 0; mwr[p] = 0; lreq[p] = 0; drop_next[p] = 0;
    end
    cbusy = 0; after_done = 0; pref = 0; cown = 0; cnt = 0; n_txn = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      hrd = host_intf_rd_o; hwr = host_intf_wr_o;
      host_intf_done_i = 0; real_done = 0;
      host_intf_rdPending_i = 1'($urandom_range(0, 1));
      for (int p = 0; p < 2; p++) begin
        justdrop[p] = drop_next[p];
        if (drop_next[p]) begin act[p] = 0; drop_next[p] = 0; end
      end
      if (!cbusy) begin
        if (hrd | hwr) begin
          if (lreq[0] && lreq[1]) g = pref;
          else if (lreq[0]) g = 0;
          else if (lreq[1]) g = 1;
          else g = -1;
          if (g < 0) begin
            chk("rand_unrequested_grant", {hrd, hwr}, 0);
          end else begin
            chk("rand_g_wr", hwr, mwr[g]);
            chk("rand_g_rd", hrd, mrd[g] & ~mwr[g]);
            chk("rand_g_addr", host_intf_addr_o, ad[g]);
            chk("rand_g_data", host_intf_data_o, dt[g]);
            cbusy = 1; cown = g; cnt = $urandom_range(1, 4); n_txn++;
          end
        end else if ((lreq[0] || lreq[1]) && !after_done) begin
          chk("rand_grant_latency", {hrd, hwr}, 1);
        end else if (!lreq[0] && !lreq[1] && ($urandom_range(0, 3) == 0)) begin
          host_intf_done_i = 1;
        end
      end else begin
        chk("rand_busy_hold", hrd | hwr, 1);
        chk("rand_busy_addr", host_intf_addr_o, ad[cown]);
        cnt--;
        if (cnt == 0) begin
          real_done = 1;
          host_intf_done_i = 1;
          if (mwr[cown]) begin
            cmem[ad[cown][3:0]] = dt[cown];
            host_intf_data_i = 16'($urandom);
          end else begin
            host_intf_data_i = cmem[ad[cown][3:0]];
          end
          rdata = host_intf_data_i;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && !justdrop[p] && ($urandom_range(0, 2) == 0)) begin
          act[p] = 1;
          mode = $urandom_range(0, 2);
          mrd[p] = (mode != 1);
          mwr[p] = (mode != 0);
          ad[p]  = 24'($urandom_range(0, 15));
          dt[p]  = 16'($urandom);
        end
      end
      p0_rd_i = act[0] & mrd[0]; p0_wr_i = act[0] & mwr[0];
      p0_addr_i = ad[0]; p0_data_i = dt[0];
      p1_rd_i = act[1] & mrd[1]; p1_wr_i = act[1] & mwr[1];
      p1_addr_i = ad[1]; p1_data_i = dt[1];
      #1;
      chk("rand_done0", p0_done_o, real_done && cown == 0);
      chk("rand_done1", p1_done_o, real_done && cown == 1);
      chk("rand_rdp0", p0_rdPending_o, host_intf_rdPending_i && cbusy && cown == 0);
      chk("rand_rdp1", p1_rdPending_o, host_intf_rdPending_i && cbusy && cown == 1);
      if (real_done && !mwr[cown])
        chk("rand_rdata", cown ? p1_data_o : p0_data_o, rdata);
      if (real_done) begin
        pref = 1 - cown;
        drop_next[cown] = 1;
        cbusy = 0;
      end
      after_done = real_done;
      lreq[0] = act[0]; lreq[1] = act[1];
    end
    if (n_txn < 100) chk("rand_txn_count_low", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
